// File: rtl/ysyx_25040129_ifu_fetch_if.sv
// Signal bundle between the fetch stage and its surroundings: instruction-memory
// read channel, PC redirect from later stages, and the decode-side valid/ready handshake.
interface ysyx_25040129_ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        is_req_valid_to_idu;
    logic        is_req_ready_from_idu;
    logic [31:0] inst;
    logic [31:0] pc_out_ifu;

    modport master (
        output imem_req_valid, imem_addr, is_req_valid_to_idu, inst, pc_out_ifu,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               redirect_valid, redirect_pc, is_req_ready_from_idu
    );

    modport slave (
        input  imem_req_valid, imem_addr, is_req_valid_to_idu, inst, pc_out_ifu,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               redirect_valid, redirect_pc, is_req_ready_from_idu
    );
endinterface

// File: rtl/ysyx_25040129_ifu_fetch.sv
// Instruction fetch stage: one outstanding imem read, holds the returned word for decode,
// squashes wrong-path fetches on redirect and counts instructions handed to decode.
module ysyx_25040129_ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h3000_0000,
    parameter logic [31:0] FAULT_INST = 32'h0010_0073
) (
    input  logic                            clock,
    input  logic                            reset,
    ysyx_25040129_ifu_fetch_if.master       bus,
    output logic [31:0]                     perf_fetch_cnt
);
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        drop;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    // Redirect masks valid in HOLD so decode never consumes a word that is being squashed.
    assign bus.imem_req_valid      = (state == REQ) && !reset;
    assign bus.imem_addr           = fetch_pc;
    assign bus.is_req_valid_to_idu = (state == HOLD) && !bus.redirect_valid;
    assign bus.inst                = inst_q;
    assign bus.pc_out_ifu          = pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= REQ;
            fetch_pc       <= RESET_PC;
            drop           <= 1'b0;
            inst_q         <= 32'h0;
            pc_q           <= 32'h0;
            perf_fetch_cnt <= 32'h0;
        end else begin
            unique case (state)
                REQ: begin
                    if (bus.redirect_valid)
                        fetch_pc <= bus.redirect_pc;
                    // An accepted request on the old PC is already wrong-path if redirected now.
                    if (bus.imem_req_ready) begin
                        state <= WAIT;
                        drop  <= bus.redirect_valid;
                    end
                end
                WAIT: begin
                    if (bus.redirect_valid) begin
                        fetch_pc <= bus.redirect_pc;
                        if (bus.imem_rsp_valid) begin
                            state <= REQ;
                            drop  <= 1'b0;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end else if (bus.imem_rsp_valid) begin
                        if (drop) begin
                            state <= REQ;
                            drop  <= 1'b0;
                        end else begin
                            inst_q <= bus.imem_rsp_err ? FAULT_INST : bus.imem_rsp_data;
                            pc_q   <= fetch_pc;
                            state  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        fetch_pc <= bus.redirect_pc;
                        state    <= REQ;
                    end else if (bus.is_req_ready_from_idu) begin
                        fetch_pc       <= pc_q + 32'd4;
                        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
                        state          <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25040129_ifu_fetch.sv
// Directed bench for the fetch stage: sequential scenarios with hand-computed expectations.
module tb_ysyx_25040129_ifu_fetch;
    localparam logic [31:0] RESET_PC   = 32'h3000_0000;
    localparam logic [31:0] FAULT_INST = 32'h0010_0073;

    logic        clock;
    logic        reset;
    logic [31:0] perf_fetch_cnt;
    int          tests;
    int          failed;

    ysyx_25040129_ifu_fetch_if bus ();

    ysyx_25040129_ifu_fetch #(
        .RESET_PC   (RESET_PC),
        .FAULT_INST (FAULT_INST)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .perf_fetch_cnt (perf_fetch_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered in REQ just after an edge; performs accept, 1-cycle response, handshake.
    task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic err, input logic [31:0] exp_inst,
                             input logic [31:0] exp_cnt);
        bus.imem_req_ready = 1'b1;
        #1;
        check({tag, "_req_valid"}, {31'h0, bus.imem_req_valid}, 32'd1);
        check({tag, "_addr"}, bus.imem_addr, addr);
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        bus.imem_rsp_err   = err;
        #1;
        check({tag, "_wait_novalid"}, {31'h0, bus.is_req_valid_to_idu}, 32'd0);
        tick();
        bus.imem_rsp_valid        = 1'b0;
        bus.imem_rsp_err          = 1'b0;
        bus.is_req_ready_from_idu = 1'b1;
        #1;
        check({tag, "_idu_valid"}, {31'h0, bus.is_req_valid_to_idu}, 32'd1);
        check({tag, "_inst"}, bus.inst, exp_inst);
        check({tag, "_pc"}, bus.pc_out_ifu, addr);
        tick();
        bus.is_req_ready_from_idu = 1'b0;
        #1;
        check({tag, "_cnt"}, perf_fetch_cnt, exp_cnt);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset                     = 1'b1;
        bus.imem_req_ready        = 1'b0;
        bus.imem_rsp_valid        = 1'b0;
        bus.imem_rsp_data         = 32'h0;
        bus.imem_rsp_err          = 1'b0;
        bus.redirect_valid        = 1'b0;
        bus.redirect_pc           = 32'h0;
        bus.is_req_ready_from_idu = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'd0);
        check("rst_idu_valid", {31'h0, bus.is_req_valid_to_idu}, 32'd0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_pc", bus.pc_out_ifu, 32'h0);
        check("rst_cnt", perf_fetch_cnt, 32'h0);
        reset = 1'b0;

        // 1: three sequential fetches
        fetch_one("seq0", 32'h3000_0000, 32'h0000_0093, 1'b0, 32'h0000_0093, 32'd1);
        fetch_one("seq1", 32'h3000_0004, 32'h0010_0113, 1'b0, 32'h0010_0113, 32'd2);
        fetch_one("seq2", 32'h3000_0008, 32'h0020_0193, 1'b0, 32'h0020_0193, 32'd3);

        // 2: decode stalls for 5 cycles in HOLD
        bus.imem_req_ready = 1'b1;
        #1;
        check("stall_addr", bus.imem_addr, 32'h3000_000C);
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", {31'h0, bus.is_req_valid_to_idu}, 32'd1);
            check("stall_inst", bus.inst, 32'hDEAD_BEEF);
            check("stall_pc", bus.pc_out_ifu, 32'h3000_000C);
            check("stall_noreq", {31'h0, bus.imem_req_valid}, 32'd0);
            tick();
        end
        bus.imem_req_ready        = 1'b0;
        bus.is_req_ready_from_idu = 1'b1;
        tick();
        bus.is_req_ready_from_idu = 1'b0;
        #1;
        check("stall_cnt", perf_fetch_cnt, 32'd4);

        // 5: bus error yields ebreak word
        fetch_one("err", 32'h3000_0010, 32'h1234_5678, 1'b1, FAULT_INST, 32'd5);

        // 3: redirect while waiting, stale response two cycles later is dropped
        bus.imem_req_ready = 1'b1;
        #1;
        check("rw_addr", bus.imem_addr, 32'h3000_0014);
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0040;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0013;
        #1;
        check("rw_rsp_novalid", {31'h0, bus.is_req_valid_to_idu}, 32'd0);
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("rw_drop_novalid", {31'h0, bus.is_req_valid_to_idu}, 32'd0);
        fetch_one("rw_new", 32'h8000_0040, 32'h1111_1111, 1'b0, 32'h1111_1111, 32'd6);

        // 4: redirect and decode-ready together in HOLD
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h2222_2222;
        tick();
        bus.imem_rsp_valid        = 1'b0;
        bus.is_req_ready_from_idu = 1'b1;
        bus.redirect_valid        = 1'b1;
        bus.redirect_pc           = 32'h8000_1000;
        #1;
        check("rh_valid_masked", {31'h0, bus.is_req_valid_to_idu}, 32'd0);
        tick();
        bus.is_req_ready_from_idu = 1'b0;
        bus.redirect_valid        = 1'b0;
        #1;
        check("rh_cnt", perf_fetch_cnt, 32'd6);
        check("rh_req_valid", {31'h0, bus.imem_req_valid}, 32'd1);
        check("rh_addr", bus.imem_addr, 32'h8000_1000);

        // Redirect coinciding with request acceptance
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_2000;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h3333_3333;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("ra_drop_novalid", {31'h0, bus.is_req_valid_to_idu}, 32'd0);
        check("ra_addr", bus.imem_addr, 32'h8000_2000);

        // Redirect and response in the same WAIT cycle
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_3000;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        check("rr_req_valid", {31'h0, bus.imem_req_valid}, 32'd1);
        check("rr_addr", bus.imem_addr, 32'h8000_3000);
        fetch_one("rr_new", 32'h8000_3000, 32'h4444_4444, 1'b0, 32'h4444_4444, 32'd7);

        // 6: reset in WAIT, stale response right after is ignored
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h5555_5555;
        #1;
        check("rs_cnt", perf_fetch_cnt, 32'd0);
        check("rs_addr", bus.imem_addr, RESET_PC);
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("rs_stale_novalid", {31'h0, bus.is_req_valid_to_idu}, 32'd0);
        check("rs_inst", bus.inst, 32'h0);
        fetch_one("rs_new", RESET_PC, 32'h6666_6666, 1'b0, 32'h6666_6666, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
